// File: rtl/btn_debounce.sv
// Push-button conditioner: per-channel two-flop synchroniser followed by a debounce FSM
// that reports a clean level and a single-cycle strobe on each qualified press.
module btn_debounce #(
    parameter int N_BTN  = 4,
    parameter int CNT_W  = 20,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] db_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Polarity is fixed before the first flop so both FSM halves always see 1 = pressed.
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw ^ {N_BTN{INVERT}};
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_chan
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             tick_q;
            logic             tick_d;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= ZERO;
                    cnt_q   <= '0;
                    tick_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    tick_q  <= tick_d;
                end
            end

            // A single opposite sample inside a window drops straight back to the stable state.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                tick_d  = 1'b0;
                case (state_q)
                    ZERO: begin
                        if (sync2_q[gi]) begin
                            state_d = WAIT1;
                            cnt_d   = '1;
                        end
                    end
                    WAIT1: begin
                        if (!sync2_q[gi]) begin
                            state_d = ZERO;
                        end else if (cnt_q == '0) begin
                            state_d = ONE;
                            tick_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ONE: begin
                        if (!sync2_q[gi]) begin
                            state_d = WAIT0;
                            cnt_d   = '1;
                        end
                    end
                    WAIT0: begin
                        if (sync2_q[gi]) begin
                            state_d = ONE;
                        end else if (cnt_q == '0) begin
                            state_d = ZERO;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ZERO;
                    end
                endcase
            end

            assign db_level[gi] = (state_q == ONE) || (state_q == WAIT0);
            assign db_tick[gi]  = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a 16-clock window: a level change on btn_raw
// becomes visible on the 19th rising edge after it is driven.
module tb_btn_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] db_level;
    logic [3:0] db_tick;
    logic [3:0] btn_inv;
    logic [3:0] level_inv;
    logic [3:0] tick_inv;

    int n_vec;
    int n_fail;

    btn_debounce #(.N_BTN(4), .CNT_W(4), .INVERT(1'b0)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .db_level(db_level),
        .db_tick (db_tick)
    );

    btn_debounce #(.N_BTN(4), .CNT_W(4), .INVERT(1'b1)) dut_inv (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_inv),
        .db_level(level_inv),
        .db_tick (tick_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int         cycles;
        logic [3:0] exp_level;
        logic [3:0] exp_tick;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] btn, input int cycles, input logic [3:0] lvl,
                       input logic [3:0] tck, input string name);
        vec_t v;
        v.btn       = btn;
        v.cycles    = cycles;
        v.exp_level = lvl;
        v.exp_tick  = tck;
        v.name      = name;
        tbl.push_back(v);
    endtask

    // Drive v.btn, then check every following cycle: level constant at exp_level,
    // tick zero except on the last cycle where it must equal exp_tick.
    task automatic apply(input vec_t v, input bit use_inv);
        int         bad_cyc;
        logic [3:0] lvl, tck, exp_t, bad_lvl, bad_tck, bad_exp_t;
        bad_cyc   = -1;
        bad_lvl   = '0;
        bad_tck   = '0;
        bad_exp_t = '0;
        if (use_inv) btn_inv = v.btn;
        else         btn_raw = v.btn;
        for (int c = 1; c <= v.cycles; c++) begin
            @(negedge clk);
            lvl   = use_inv ? level_inv : db_level;
            tck   = use_inv ? tick_inv  : db_tick;
            exp_t = (c == v.cycles) ? v.exp_tick : 4'b0000;
            if (bad_cyc < 0 && (lvl !== v.exp_level || tck !== exp_t)) begin
                bad_cyc   = c;
                bad_lvl   = lvl;
                bad_tck   = tck;
                bad_exp_t = exp_t;
            end
        end
        n_vec++;
        if (bad_cyc >= 0) begin
            n_fail++;
            $display("FAIL %s cycle %0d/%0d: level=%b tick=%b, expected level=%b tick=%b",
                     v.name, bad_cyc, v.cycles, bad_lvl, bad_tck, v.exp_level, bad_exp_t);
        end else begin
            $display("ok   %-16s btn=%b cycles=%0d level=%b tick=%b",
                     v.name, v.btn, v.cycles, v.exp_level, v.exp_tick);
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] lvl, input logic [3:0] tck);
        n_vec++;
        if (lvl !== 4'b0000 || tck !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: level=%b tick=%b, expected level=0000 tick=0000", name, lvl, tck);
        end else begin
            $display("ok   %-16s level=0000 tick=0000", name);
        end
    endtask

    task automatic run(input logic [3:0] btn, input int cycles, input logic [3:0] lvl,
                       input logic [3:0] tck, input string name, input bit use_inv);
        vec_t v;
        v.btn       = btn;
        v.cycles    = cycles;
        v.exp_level = lvl;
        v.exp_tick  = tck;
        v.name      = name;
        apply(v, use_inv);
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        btn_raw = 4'b0000;
        btn_inv = 4'b1111;

        // Single clean press on channel 0, held 40 clocks
        add(4'b0001, 18, 4'b0000, 4'b0000, "t1_window");
        add(4'b0001,  1, 4'b0001, 4'b0001, "t1_press");
        add(4'b0001, 21, 4'b0001, 4'b0000, "t1_hold");
        // Release with a 3-clock high glitch 5 clocks in: level holds, no tick
        add(4'b0000,  5, 4'b0001, 4'b0000, "t3_fall");
        add(4'b0001,  3, 4'b0001, 4'b0000, "t3_glitch");
        add(4'b0000, 18, 4'b0001, 4'b0000, "t3_window");
        add(4'b0000,  1, 4'b0000, 4'b0000, "t3_released");
        add(4'b0000,  3, 4'b0000, 4'b0000, "t3_idle");
        // Bounce on channel 1: 10 high, 2 low, then held high 40
        add(4'b0010, 10, 4'b0000, 4'b0000, "t2_bounce_hi");
        add(4'b0000,  2, 4'b0000, 4'b0000, "t2_bounce_lo");
        add(4'b0010, 18, 4'b0000, 4'b0000, "t2_window");
        add(4'b0010,  1, 4'b0010, 4'b0010, "t2_press");
        add(4'b0010, 21, 4'b0010, 4'b0000, "t2_hold");
        add(4'b0000, 18, 4'b0010, 4'b0000, "t2_rel_window");
        add(4'b0000,  3, 4'b0000, 4'b0000, "t2_released");
        // Shortest pulses: 16 clocks is rejected, 17 clocks qualifies
        add(4'b1000, 16, 4'b0000, 4'b0000, "p16_high");
        add(4'b0000, 25, 4'b0000, 4'b0000, "p16_rejected");
        add(4'b1000, 17, 4'b0000, 4'b0000, "p17_high");
        add(4'b0000,  1, 4'b0000, 4'b0000, "p17_pending");
        add(4'b0000,  1, 4'b1000, 4'b1000, "p17_press");
        add(4'b0000, 16, 4'b1000, 4'b0000, "p17_rel_window");
        add(4'b0000,  3, 4'b0000, 4'b0000, "p17_released");
        // All four channels pressed on the same edge
        add(4'b1111, 18, 4'b0000, 4'b0000, "t5_window");
        add(4'b1111,  1, 4'b1111, 4'b1111, "t5_press_all");
        add(4'b1111,  5, 4'b1111, 4'b0000, "t5_hold");
        add(4'b0000, 18, 4'b1111, 4'b0000, "t5_rel_window");
        add(4'b0000,  3, 4'b0000, 4'b0000, "t5_released");

        repeat (3) @(negedge clk);
        check_now("reset_state", db_level, db_tick);
        check_now("reset_state_inv", level_inv, tick_inv);
        reset = 1'b0;

        // Inverted build idles high and must stay released
        run(4'b1111, 20, 4'b0000, 4'b0000, "t6_idle_high", 1'b1);

        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // Reset in the middle of channel 2's window while channel 0 is already pressed
        run(4'b0001, 18, 4'b0000, 4'b0000, "t4_ch0_window", 1'b0);
        run(4'b0001,  1, 4'b0001, 4'b0001, "t4_ch0_press", 1'b0);
        run(4'b0101, 10, 4'b0001, 4'b0000, "t4_ch2_window", 1'b0);
        reset = 1'b1;
        #1;
        check_now("t4_async_clear", db_level, db_tick);
        run(4'b0101,  3, 4'b0000, 4'b0000, "t4_in_reset", 1'b0);
        reset = 1'b0;
        run(4'b0101, 18, 4'b0000, 4'b0000, "t4_requal", 1'b0);
        run(4'b0101,  1, 4'b0101, 4'b0101, "t4_requal_press", 1'b0);
        run(4'b0101,  3, 4'b0101, 4'b0000, "t4_hold", 1'b0);
        run(4'b0000, 18, 4'b0101, 4'b0000, "t4_rel_window", 1'b0);
        run(4'b0000,  2, 4'b0000, 4'b0000, "t4_released", 1'b0);

        // Active-low press on the inverted build, held 40 clocks
        run(4'b1110, 18, 4'b0000, 4'b0000, "t6_window", 1'b1);
        run(4'b1110,  1, 4'b0001, 4'b0001, "t6_press", 1'b1);
        run(4'b1110, 21, 4'b0001, 4'b0000, "t6_hold", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
